// File: rtl/mem_copy_master.sv
// Byte-at-a-time memory copy initiator for the z23 synchronous byte memory.
// Alternates READ (source address) and WRITE (destination address) states, ascending addresses.
module mem_copy_master #(
  parameter int unsigned        ADDR_W    = 16,
  parameter int unsigned        LEN_W     = 16,
  parameter logic [ADDR_W-1:0]  IDLE_ADDR = '0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  remaining,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] dst_nxt;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_nxt;

  // State and copy-pointer registers; reset aborts any copy in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_IDLE;
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      src_q <= src_nxt;
      dst_q <= dst_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  // Next state, pointer updates and the memory-port drive, all decoded from the current state.
  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    dst_nxt   = dst_q;
    cnt_nxt   = cnt_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = IDLE_ADDR;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;

    case (state)
      ST_IDLE: begin
        if (start) begin
          src_nxt   = src_addr;
          dst_nxt   = dst_addr;
          cnt_nxt   = length;
          state_nxt = (length == '0) ? ST_DONE : ST_READ;
        end
      end

      ST_READ: begin
        busy      = 1'b1;
        mem_addr  = src_q;
        state_nxt = ST_WRITE;
      end

      // Memory holds the byte read in the previous cycle while mem_wr is high.
      ST_WRITE: begin
        busy      = 1'b1;
        mem_addr  = dst_q;
        mem_wr    = 1'b1;
        mem_wdata = mem_rdata;
        src_nxt   = src_q + ADDR_W'(1);
        dst_nxt   = dst_q + ADDR_W'(1);
        cnt_nxt   = cnt_q - LEN_W'(1);
        state_nxt = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_READ;
      end

      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign remaining = cnt_q;

endmodule
